// File: rtl/mem_defs.sv
// Shared memory-access definitions: access-size encodings (also used by the
// load writeback path) and the store FSM state encodings.
package mem_defs;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_DONE  = 2'b11
  } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane alignment: places LSB-justified store data and its
// byte mask onto an 8-lane (two-word) window starting at the address offset.
module store_lane_align
  import mem_defs::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_be,
  output logic        illegal
);

  logic [3:0]  mask;
  logic [31:0] masked;

  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: illegal = 1'b1;
    endcase
    // Zero bytes above the access size so unused lanes never carry stale rs2 bits.
    masked    = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    wide_be   = {4'b0000, mask} << off;
    wide_data = {32'b0, masked} << {off, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: turns one execute-stage store into word-aligned dmem write beats.
// Cross-word splitting into two beats is built only when STORE_SPLIT_EN is defined.
//   state | meaning
//   IDLE  | ready for a new store
//   BEAT0 | first (or only) write beat valid, waiting for dmem_wr_ready
//   BEAT1 | second beat of a cross-word store (STORE_SPLIT_EN only)
//   DONE  | one cycle, pulses st_done or st_fault
module store_unit
  import mem_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        mem_access_size,
  output logic              dmem_wr_valid,
  input  logic              dmem_wr_ready,
  output logic [ADDR_W-1:0] dmem_wr_addr,
  output logic [DATA_W-1:0] dmem_wr_data,
  output logic [3:0]        dmem_wr_be,
  output logic              st_done,
  output logic              st_fault
);

  st_state_e   state, state_nxt;
  logic [63:0] wide_data;
  logic [7:0]  wide_be;
  logic        illegal;
  logic        needs_split;
  logic        reject;
  logic        accept;
  logic        fault_q;

  store_lane_align u_align (
    .off       (st_addr[1:0]),
    .size      (mem_access_size),
    .data      (st_data),
    .wide_data (wide_data),
    .wide_be   (wide_be),
    .illegal   (illegal)
  );

  assign needs_split = |wide_be[7:4];
  assign accept      = st_valid && (state == ST_IDLE);

`ifdef STORE_SPLIT_EN
  logic              split_q;
  logic [ADDR_W-1:0] b1_addr_q;
  logic [31:0]       b1_data_q;
  logic [3:0]        b1_be_q;
  assign reject = illegal;
`else
  logic unused_hi;
  assign unused_hi = ^wide_data[63:32];
  assign reject    = illegal || needs_split;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (st_valid) state_nxt = reject ? ST_DONE : ST_BEAT0;
`ifdef STORE_SPLIT_EN
      ST_BEAT0: if (dmem_wr_ready) state_nxt = split_q ? ST_BEAT1 : ST_DONE;
      ST_BEAT1: if (dmem_wr_ready) state_nxt = ST_DONE;
`else
      ST_BEAT0: if (dmem_wr_ready) state_nxt = ST_DONE;
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_wr_valid <= 1'b0;
      dmem_wr_addr  <= '0;
      dmem_wr_data  <= '0;
      dmem_wr_be    <= '0;
      fault_q       <= 1'b0;
`ifdef STORE_SPLIT_EN
      split_q       <= 1'b0;
      b1_addr_q     <= '0;
      b1_data_q     <= '0;
      b1_be_q       <= '0;
`endif
    end else if (accept) begin
      fault_q <= reject;
      if (!reject) begin
        dmem_wr_valid <= 1'b1;
        dmem_wr_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
        dmem_wr_data  <= wide_data[31:0];
        dmem_wr_be    <= wide_be[3:0];
      end
`ifdef STORE_SPLIT_EN
      split_q   <= needs_split;
      b1_addr_q <= {st_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
      b1_data_q <= wide_data[63:32];
      b1_be_q   <= wide_be[7:4];
`endif
    end else if (dmem_wr_valid && dmem_wr_ready) begin
`ifdef STORE_SPLIT_EN
      if (state == ST_BEAT0 && split_q) begin
        dmem_wr_addr <= b1_addr_q;
        dmem_wr_data <= b1_data_q;
        dmem_wr_be   <= b1_be_q;
      end else begin
        dmem_wr_valid <= 1'b0;
      end
`else
      dmem_wr_valid <= 1'b0;
`endif
    end
  end

  assign st_ready = (state == ST_IDLE);
  assign st_done  = (state == ST_DONE) && !fault_q;
  assign st_fault = (state == ST_DONE) && fault_q;

endmodule
